// File: rtl/issue_hazard_stage.sv
// Issue stage: buffers one decoded even/odd pair, checks it against a countdown
// scoreboard of in-flight destinations, and issues each slot through registered outputs.
module issue_hazard_stage #(
    parameter int NUM_REGS = 128,
    parameter int LAT_W    = 4,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    input  logic [31:0]      dec_even_full_instr,
    input  logic [6:0]       dec_even_instr_id,
    input  logic [6:0]       dec_even_reg_dst,
    input  logic [2:0]       dec_even_unit_id,
    input  logic [LAT_W-1:0] dec_even_latency,
    input  logic             dec_even_reg_wr,
    input  logic [6:0]       dec_even_imme7,
    input  logic [9:0]       dec_even_imme10,
    input  logic [15:0]      dec_even_imme16,
    input  logic [17:0]      dec_even_imme18,
    input  logic [6:0]       dec_even_ra_addr,
    input  logic [6:0]       dec_even_rb_addr,
    input  logic [6:0]       dec_even_rc_addr,
    input  logic             dec_even_ra_use,
    input  logic             dec_even_rb_use,
    input  logic             dec_even_rc_use,
    input  logic [31:0]      dec_odd_full_instr,
    input  logic [6:0]       dec_odd_instr_id,
    input  logic [6:0]       dec_odd_reg_dst,
    input  logic [2:0]       dec_odd_unit_id,
    input  logic [LAT_W-1:0] dec_odd_latency,
    input  logic             dec_odd_reg_wr,
    input  logic [6:0]       dec_odd_imme7,
    input  logic [9:0]       dec_odd_imme10,
    input  logic [15:0]      dec_odd_imme16,
    input  logic [17:0]      dec_odd_imme18,
    input  logic [6:0]       dec_odd_ra_addr,
    input  logic [6:0]       dec_odd_rb_addr,
    input  logic [6:0]       dec_odd_rc_addr,
    input  logic             dec_odd_ra_use,
    input  logic             dec_odd_rb_use,
    input  logic             dec_odd_rc_use,
    output logic [31:0]      full_instr_even,
    output logic [6:0]       instr_id_even,
    output logic [6:0]       reg_dst_even,
    output logic [2:0]       unit_id_even,
    output logic [LAT_W-1:0] latency_even,
    output logic             reg_wr_even,
    output logic [6:0]       imme7_even,
    output logic [9:0]       imme10_even,
    output logic [15:0]      imme16_even,
    output logic [17:0]      imme18_even,
    output logic [6:0]       ra_addr_even,
    output logic [6:0]       rb_addr_even,
    output logic [6:0]       rc_addr_even,
    output logic [31:0]      full_instr_odd,
    output logic [6:0]       instr_id_odd,
    output logic [6:0]       reg_dst_odd,
    output logic [2:0]       unit_id_odd,
    output logic [LAT_W-1:0] latency_odd,
    output logic             reg_wr_odd,
    output logic [6:0]       imme7_odd,
    output logic [9:0]       imme10_odd,
    output logic [15:0]      imme16_odd,
    output logic [17:0]      imme18_odd,
    output logic [6:0]       ra_addr_odd,
    output logic [6:0]       rb_addr_odd,
    output logic [6:0]       rc_addr_odd,
    output logic [CNT_W-1:0] stall_count
);
    localparam int RA_W = 7;

    typedef struct packed {
        logic [31:0]      full_instr;
        logic [6:0]       instr_id;
        logic [6:0]       reg_dst;
        logic [2:0]       unit_id;
        logic [LAT_W-1:0] latency;
        logic             reg_wr;
        logic [6:0]       imme7;
        logic [9:0]       imme10;
        logic [15:0]      imme16;
        logic [17:0]      imme18;
        logic [6:0]       ra_addr;
        logic [6:0]       rb_addr;
        logic [6:0]       rc_addr;
    } out_t;

    typedef struct packed {
        out_t f;
        logic ra_use;
        logic rb_use;
        logic rc_use;
    } slot_t;

    typedef enum logic [1:0] {
        ST_EMPTY    = 2'd0,
        ST_PAIR     = 2'd1,
        ST_ODD_ONLY = 2'd2
    } state_e;

    state_e             state_q, state_d;
    slot_t              even_q, odd_q;
    out_t               out_even_q, out_odd_q;
    logic [LAT_W-1:0]   sb_q [NUM_REGS];
    logic [CNT_W-1:0]   stall_q, stall_d;
    logic [NUM_REGS-1:0] busy_s;
    slot_t              dec_even_s, dec_odd_s;
    logic               even_go_s, odd_go_s, all_done_s, stall_inc_s, accept_s;

    // A slot may issue only if none of its sources or its destination is still in flight.
    function automatic logic slot_ok(input slot_t s, input logic [NUM_REGS-1:0] busy);
        slot_ok = !((s.ra_use && busy[s.f.ra_addr]) || (s.rb_use && busy[s.f.rb_addr]) ||
                    (s.rc_use && busy[s.f.rc_addr]) || (s.f.reg_wr && busy[s.f.reg_dst]));
    endfunction

    function automatic logic pair_conflict(input slot_t e, input slot_t o);
        pair_conflict = e.f.reg_wr &&
            ((o.ra_use && (o.f.ra_addr == e.f.reg_dst)) || (o.rb_use && (o.f.rb_addr == e.f.reg_dst)) ||
             (o.rc_use && (o.f.rc_addr == e.f.reg_dst)) || (o.f.reg_wr && (o.f.reg_dst == e.f.reg_dst)));
    endfunction

    assign dec_even_s = {dec_even_full_instr, dec_even_instr_id, dec_even_reg_dst, dec_even_unit_id,
                         dec_even_latency, dec_even_reg_wr, dec_even_imme7, dec_even_imme10,
                         dec_even_imme16, dec_even_imme18, dec_even_ra_addr, dec_even_rb_addr,
                         dec_even_rc_addr, dec_even_ra_use, dec_even_rb_use, dec_even_rc_use};
    assign dec_odd_s  = {dec_odd_full_instr, dec_odd_instr_id, dec_odd_reg_dst, dec_odd_unit_id,
                         dec_odd_latency, dec_odd_reg_wr, dec_odd_imme7, dec_odd_imme10,
                         dec_odd_imme16, dec_odd_imme18, dec_odd_ra_addr, dec_odd_rb_addr,
                         dec_odd_rc_addr, dec_odd_ra_use, dec_odd_rb_use, dec_odd_rc_use};

    // Busy vector: one bit per register that still has a pending write.
    always_comb begin
        busy_s = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            busy_s[i] = (sb_q[i] != LAT_W'(0));
        end
    end

    // Issue decisions, pair completion and stall detection; flush suppresses all issue.
    always_comb begin
        even_go_s   = 1'b0;
        odd_go_s    = 1'b0;
        all_done_s  = 1'b0;
        stall_inc_s = 1'b0;
        if (!flush) begin
            case (state_q)
                ST_PAIR: begin
                    even_go_s = slot_ok(even_q, busy_s);
                    odd_go_s  = even_go_s && slot_ok(odd_q, busy_s) && !pair_conflict(even_q, odd_q);
                end
                ST_ODD_ONLY: odd_go_s = slot_ok(odd_q, busy_s);
                default: begin
                    even_go_s = 1'b0;
                    odd_go_s  = 1'b0;
                end
            endcase
        end else begin
            even_go_s = 1'b0;
            odd_go_s  = 1'b0;
        end
        case (state_q)
            ST_EMPTY: begin
                all_done_s  = 1'b1;
                stall_inc_s = 1'b0;
            end
            ST_PAIR: begin
                all_done_s  = even_go_s && odd_go_s;
                stall_inc_s = !even_go_s;
            end
            ST_ODD_ONLY: begin
                all_done_s  = odd_go_s;
                stall_inc_s = !odd_go_s;
            end
            default: begin
                all_done_s  = 1'b0;
                stall_inc_s = 1'b0;
            end
        endcase
    end

    assign in_ready = rst && !flush && all_done_s;
    assign accept_s = in_valid && in_ready;

    // Next-state: a newly accepted pair always replaces whatever just drained.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_EMPTY;
        end else if (accept_s) begin
            state_d = ST_PAIR;
        end else begin
            case (state_q)
                ST_PAIR: begin
                    if (even_go_s && odd_go_s) begin
                        state_d = ST_EMPTY;
                    end else if (even_go_s) begin
                        state_d = ST_ODD_ONLY;
                    end else begin
                        state_d = ST_PAIR;
                    end
                end
                ST_ODD_ONLY: state_d = odd_go_s ? ST_EMPTY : ST_ODD_ONLY;
                default:     state_d = ST_EMPTY;
            endcase
        end
        stall_d = (stall_inc_s && (stall_q != {CNT_W{1'b1}})) ? stall_q + CNT_W'(1) : stall_q;
    end

    // Control, pair buffer and registered issue outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_EMPTY;
            even_q     <= '0;
            odd_q      <= '0;
            out_even_q <= '0;
            out_odd_q  <= '0;
            stall_q    <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            if (accept_s) begin
                even_q <= dec_even_s;
                odd_q  <= dec_odd_s;
            end
            out_even_q <= even_go_s ? even_q.f : '0;
            out_odd_q  <= odd_go_s ? odd_q.f : '0;
        end
    end

    // Scoreboard countdown; a fresh issue write overrides the decrement.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                sb_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (even_go_s && even_q.f.reg_wr && (even_q.f.latency != LAT_W'(0)) &&
                    (even_q.f.reg_dst == RA_W'(i))) begin
                    sb_q[i] <= even_q.f.latency;
                end else if (odd_go_s && odd_q.f.reg_wr && (odd_q.f.latency != LAT_W'(0)) &&
                             (odd_q.f.reg_dst == RA_W'(i))) begin
                    sb_q[i] <= odd_q.f.latency;
                end else if (sb_q[i] != LAT_W'(0)) begin
                    sb_q[i] <= sb_q[i] - LAT_W'(1);
                end
            end
        end
    end

    assign {full_instr_even, instr_id_even, reg_dst_even, unit_id_even, latency_even, reg_wr_even,
            imme7_even, imme10_even, imme16_even, imme18_even, ra_addr_even, rb_addr_even,
            rc_addr_even} = out_even_q;
    assign {full_instr_odd, instr_id_odd, reg_dst_odd, unit_id_odd, latency_odd, reg_wr_odd,
            imme7_odd, imme10_odd, imme16_odd, imme18_odd, ra_addr_odd, rb_addr_odd,
            rc_addr_odd} = out_odd_q;
    assign stall_count = stall_q;

endmodule

// File: tb/tb_issue_hazard_stage.sv
// Directed bench for issue_hazard_stage: a queue/array model of the issue rules is
// checked every cycle, plus literal expectations for each scenario.
module tb_issue_hazard_stage;

    typedef struct packed {
        logic [31:0] full;
        logic [6:0]  id;
        logic [6:0]  dst;
        logic [2:0]  unit;
        logic [3:0]  lat;
        logic        wr;
        logic [6:0]  i7;
        logic [9:0]  i10;
        logic [15:0] i16;
        logic [17:0] i18;
        logic [6:0]  ra;
        logic [6:0]  rb;
        logic [6:0]  rc;
        logic        rau;
        logic        rbu;
        logic        rcu;
    } slot_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic in_valid = 1'b0;
    logic flush = 1'b0;
    logic in_ready;
    slot_t dev = '0;
    slot_t dod = '0;

    logic [31:0] full_instr_even, full_instr_odd;
    logic [6:0]  instr_id_even, instr_id_odd, reg_dst_even, reg_dst_odd;
    logic [2:0]  unit_id_even, unit_id_odd;
    logic [3:0]  latency_even, latency_odd;
    logic        reg_wr_even, reg_wr_odd;
    logic [6:0]  imme7_even, imme7_odd;
    logic [9:0]  imme10_even, imme10_odd;
    logic [15:0] imme16_even, imme16_odd;
    logic [17:0] imme18_even, imme18_odd;
    logic [6:0]  ra_addr_even, rb_addr_even, rc_addr_even;
    logic [6:0]  ra_addr_odd, rb_addr_odd, rc_addr_odd;
    logic [31:0] stall_count;

    int n_cmp = 0;
    int n_bad = 0;

    slot_t       pend[$];
    int          sb_m[128];
    logic [31:0] stall_m = '0;
    slot_t       exp_e = '0;
    slot_t       exp_o = '0;

    issue_hazard_stage dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .dec_even_full_instr(dev.full), .dec_even_instr_id(dev.id), .dec_even_reg_dst(dev.dst),
        .dec_even_unit_id(dev.unit), .dec_even_latency(dev.lat), .dec_even_reg_wr(dev.wr),
        .dec_even_imme7(dev.i7), .dec_even_imme10(dev.i10), .dec_even_imme16(dev.i16),
        .dec_even_imme18(dev.i18), .dec_even_ra_addr(dev.ra), .dec_even_rb_addr(dev.rb),
        .dec_even_rc_addr(dev.rc), .dec_even_ra_use(dev.rau), .dec_even_rb_use(dev.rbu),
        .dec_even_rc_use(dev.rcu),
        .dec_odd_full_instr(dod.full), .dec_odd_instr_id(dod.id), .dec_odd_reg_dst(dod.dst),
        .dec_odd_unit_id(dod.unit), .dec_odd_latency(dod.lat), .dec_odd_reg_wr(dod.wr),
        .dec_odd_imme7(dod.i7), .dec_odd_imme10(dod.i10), .dec_odd_imme16(dod.i16),
        .dec_odd_imme18(dod.i18), .dec_odd_ra_addr(dod.ra), .dec_odd_rb_addr(dod.rb),
        .dec_odd_rc_addr(dod.rc), .dec_odd_ra_use(dod.rau), .dec_odd_rb_use(dod.rbu),
        .dec_odd_rc_use(dod.rcu),
        .full_instr_even(full_instr_even), .instr_id_even(instr_id_even), .reg_dst_even(reg_dst_even),
        .unit_id_even(unit_id_even), .latency_even(latency_even), .reg_wr_even(reg_wr_even),
        .imme7_even(imme7_even), .imme10_even(imme10_even), .imme16_even(imme16_even),
        .imme18_even(imme18_even), .ra_addr_even(ra_addr_even), .rb_addr_even(rb_addr_even),
        .rc_addr_even(rc_addr_even),
        .full_instr_odd(full_instr_odd), .instr_id_odd(instr_id_odd), .reg_dst_odd(reg_dst_odd),
        .unit_id_odd(unit_id_odd), .latency_odd(latency_odd), .reg_wr_odd(reg_wr_odd),
        .imme7_odd(imme7_odd), .imme10_odd(imme10_odd), .imme16_odd(imme16_odd),
        .imme18_odd(imme18_odd), .ra_addr_odd(ra_addr_odd), .rb_addr_odd(rb_addr_odd),
        .rc_addr_odd(rc_addr_odd),
        .stall_count(stall_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [125:0] outv(input slot_t s);
        return {s.full, s.id, s.dst, s.unit, s.lat, s.wr, s.i7, s.i10, s.i16, s.i18, s.ra, s.rb, s.rc};
    endfunction

    function automatic slot_t mk(input logic [6:0] id, input logic [6:0] dst, input logic [3:0] lat,
                                 input logic wr, input logic [6:0] ra, input logic rau,
                                 input logic [6:0] rb, input logic rbu, input logic [6:0] rc,
                                 input logic rcu);
        slot_t s;
        s.full = {id, dst, 18'h2A5A5};
        s.id = id;   s.dst = dst;  s.unit = id[2:0]; s.lat = lat; s.wr = wr;
        s.i7 = dst;  s.i10 = {3'b101, id}; s.i16 = {id, 9'h1F3}; s.i18 = {id, 11'h4C5};
        s.ra = ra;   s.rb = rb;    s.rc = rc;
        s.rau = rau; s.rbu = rbu;  s.rcu = rcu;
        return s;
    endfunction

    // Model: an instruction may go when nothing it reads or writes is still counting down.
    function automatic bit ok(input slot_t s);
        return !((s.rau && sb_m[s.ra] != 0) || (s.rbu && sb_m[s.rb] != 0) ||
                 (s.rcu && sb_m[s.rc] != 0) || (s.wr && sb_m[s.dst] != 0));
    endfunction

    function automatic bit dep(input slot_t e, input slot_t o);
        if (!e.wr) return 1'b0;
        return (o.rau && o.ra == e.dst) || (o.rbu && o.rb == e.dst) ||
               (o.rcu && o.rc == e.dst) || (o.wr && o.dst == e.dst);
    endfunction

    function automatic void decide(output bit ge, output bit go, output bit rdy);
        bit done;
        ge = 1'b0;
        go = 1'b0;
        if (!flush) begin
            if (pend.size() == 2) begin
                ge = ok(pend[0]);
                go = ge && ok(pend[1]) && !dep(pend[0], pend[1]);
            end else if (pend.size() == 1) begin
                go = ok(pend[0]);
            end
        end
        done = (pend.size() == 0) || (pend.size() == 2 ? (ge && go) : go);
        rdy = rst && !flush && done;
    endfunction

    // Reference model update on every clock edge (pending list front = oldest slot).
    always @(posedge clk or negedge rst) begin : model
        bit ge, go, rdy;
        slot_t ne, no;
        if (!rst) begin
            pend.delete();
            foreach (sb_m[i]) sb_m[i] = 0;
            stall_m = '0;
            exp_e = '0;
            exp_o = '0;
        end else begin
            decide(ge, go, rdy);
            ne = '0;
            no = '0;
            if (pend.size() == 2) begin
                if (ge) ne = pend[0];
                if (go) no = pend[1];
            end else if (pend.size() == 1) begin
                if (go) no = pend[0];
            end
            if (pend.size() != 0 && !(pend.size() == 2 ? ge : go) && stall_m != 32'hFFFF_FFFF)
                stall_m = stall_m + 32'd1;
            foreach (sb_m[i]) if (sb_m[i] > 0) sb_m[i] = sb_m[i] - 1;
            if (ne.wr && ne.lat != 4'd0) sb_m[ne.dst] = int'(ne.lat);
            if (no.wr && no.lat != 4'd0) sb_m[no.dst] = int'(no.lat);
            if (flush) pend.delete();
            else if (go) pend.delete();
            else if (ge) void'(pend.pop_front());
            if (rdy && in_valid) begin
                pend.push_back(dev);
                pend.push_back(dod);
            end
            exp_e = ne;
            exp_o = no;
        end
    end

    // Per-cycle comparison of every DUT output against the model.
    always @(negedge clk) begin : compare
        bit ge, go, rdy;
        decide(ge, go, rdy);
        chk("even_bundle", 128'({full_instr_even, instr_id_even, reg_dst_even, unit_id_even,
             latency_even, reg_wr_even, imme7_even, imme10_even, imme16_even, imme18_even,
             ra_addr_even, rb_addr_even, rc_addr_even}), 128'(outv(exp_e)));
        chk("odd_bundle", 128'({full_instr_odd, instr_id_odd, reg_dst_odd, unit_id_odd,
             latency_odd, reg_wr_odd, imme7_odd, imme10_odd, imme16_odd, imme18_odd,
             ra_addr_odd, rb_addr_odd, rc_addr_odd}), 128'(outv(exp_o)));
        chk("in_ready", 128'(in_ready), 128'(rdy));
        chk("stall_count", 128'(stall_count), 128'(stall_m));
    end

    task automatic wait_edge();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input slot_t e, input slot_t o);
        int n = 0;
        dev = e;
        dod = o;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 60) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", 128'(in_ready), 128'(1'b1));
        @(posedge clk);
        #2;
        in_valid = 1'b0;
        dev = '0;
        dod = '0;
    endtask

    task automatic wait_id(input bit odd, input logic [6:0] id, output int n);
        n = 0;
        while ((odd ? instr_id_odd : instr_id_even) != id && n < 30) begin
            wait_edge();
            n++;
        end
    endtask

    task automatic idle(input int k);
        repeat (k) wait_edge();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stim
        int n;
        slot_t z;
        z = '0;
        // Reset then idle
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("reset_in_ready", 128'(in_ready), 128'(1'b1));
        chk("reset_stall", 128'(stall_count), 128'(0));
        chk("reset_even_nop", 128'(full_instr_even), 128'(0));
        idle(2);

        // Independent pair, then probe scoreboard[6]=7 via a dependent read
        send(mk(7'd47, 7'd5, 4'd4, 1'b1, 7'd2, 1'b1, 7'd3, 1'b1, 7'd0, 1'b0),
             mk(7'd75, 7'd6, 4'd7, 1'b1, 7'd3, 1'b1, 7'd4, 1'b1, 7'd0, 1'b0));
        wait_edge();
        chk("indep_id_even", 128'(instr_id_even), 128'(47));
        chk("indep_id_odd", 128'(instr_id_odd), 128'(75));
        chk("indep_ra_even", 128'(ra_addr_even), 128'(2));
        chk("indep_ra_odd", 128'(ra_addr_odd), 128'(3));
        chk("indep_lat_odd", 128'(latency_odd), 128'(7));
        send(mk(7'd50, 7'd0, 4'd0, 1'b0, 7'd6, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0), z);
        wait_id(1'b0, 7'd50, n);
        chk("sb6_countdown", 128'(n), 128'(7));
        chk("sb6_stalls", 128'(stall_count), 128'(6));
        idle(16);

        // Reset mid-operation drops the pair and clears the scoreboard
        send(mk(7'd60, 7'd3, 4'd15, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0), z);
        wait_edge();
        chk("mid_pre_id", 128'(instr_id_even), 128'(60));
        #1 rst = 1'b0;
        #1;
        chk("mid_rst_id", 128'(instr_id_even), 128'(0));
        chk("mid_rst_stall", 128'(stall_count), 128'(0));
        chk("mid_rst_ready", 128'(in_ready), 128'(1'b0));
        wait_edge();
        rst = 1'b1;
        send(mk(7'd61, 7'd0, 4'd0, 1'b0, 7'd3, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0), z);
        wait_id(1'b0, 7'd61, n);
        chk("mid_sb_cleared", 128'(n), 128'(1));
        idle(4);

        // RAW across pairs
        send(mk(7'd70, 7'd1, 4'd4, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0),
             mk(7'd71, 7'd20, 4'd1, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0));
        send(mk(7'd90, 7'd0, 4'd0, 1'b0, 7'd1, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0), z);
        wait_id(1'b0, 7'd90, n);
        chk("raw_issue_cycle", 128'(n), 128'(5));
        chk("raw_stalls", 128'(stall_count), 128'(4));
        idle(8);

        // Intra-pair dependency
        send(mk(7'd11, 7'd1, 4'd2, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0),
             mk(7'd12, 7'd0, 4'd0, 1'b0, 7'd1, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0));
        wait_edge();
        chk("intra_even_alone", 128'(instr_id_even), 128'(11));
        chk("intra_odd_nop", 128'(instr_id_odd), 128'(0));
        wait_id(1'b1, 7'd12, n);
        chk("intra_odd_after", 128'(n), 128'(3));
        chk("intra_odd_ra", 128'(ra_addr_odd), 128'(1));
        chk("intra_stalls", 128'(stall_count), 128'(6));
        idle(8);

        // WAW split
        send(mk(7'd21, 7'd9, 4'd3, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0),
             mk(7'd22, 7'd9, 4'd2, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0));
        wait_edge();
        chk("waw_even", 128'(instr_id_even), 128'(21));
        chk("waw_odd_nop", 128'(instr_id_odd), 128'(0));
        wait_id(1'b1, 7'd22, n);
        chk("waw_odd_after", 128'(n), 128'(4));
        chk("waw_stalls", 128'(stall_count), 128'(9));
        idle(8);

        // Latency-0 write leaves scoreboard[9] at zero
        send(mk(7'd31, 7'd9, 4'd0, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0),
             mk(7'd33, 7'd0, 4'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0));
        send(mk(7'd34, 7'd0, 4'd0, 1'b0, 7'd9, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0), z);
        wait_id(1'b0, 7'd34, n);
        chk("lat0_no_block", 128'(n), 128'(1));
        chk("lat0_stalls", 128'(stall_count), 128'(9));
        idle(8);

        // Flush while the odd slot waits with scoreboard[1]=3
        send(mk(7'd41, 7'd1, 4'd4, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0, 7'd0, 1'b0),
             mk(7'd42, 7'd0, 4'd0, 1'b0, 7'd1, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0));
        wait_edge();
        chk("flush_even", 128'(instr_id_even), 128'(41));
        wait_edge();
        flush = 1'b1;
        #1;
        chk("flush_ready_low", 128'(in_ready), 128'(1'b0));
        @(posedge clk);
        #2 flush = 1'b0;
        #1;
        chk("flush_ready_after", 128'(in_ready), 128'(1'b1));
        chk("flush_odd_nop", 128'(instr_id_odd), 128'(0));
        send(mk(7'd43, 7'd0, 4'd0, 1'b0, 7'd1, 1'b1, 7'd0, 1'b0, 7'd0, 1'b0), z);
        wait_id(1'b0, 7'd43, n);
        chk("flush_sb_kept", 128'(n), 128'(2));
        idle(8);

        // Mixed traffic over a small register window
        for (int k = 0; k < 24; k++) begin
            send(mk(7'(k + 100), 7'($urandom_range(0, 7)), 4'($urandom_range(0, 5)),
                    1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    7'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1))),
                 mk(7'(k + 1), 7'($urandom_range(0, 7)), 4'($urandom_range(0, 5)),
                    1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                    7'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)),
                    1'($urandom_range(0, 1))));
        end
        idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
